mips_debug_unit: RTL and testbench

MIPS_DEBUG_UNIT -- requirements
Module: mips_debug_unit

---
 rtl/mips_debug_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_mips_debug_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_debug_unit.sv
// Host-side debug controller for a small MIPS core: loads program words received
// over a byte link, runs or single-steps the core, and reports the halted PC.
module mips_debug_unit #(
  parameter int LEN               = 32,
  parameter int RAM_DEPTH_PROGRAM = 32,
  parameter int NB_PADDR          = 5
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_start,
  input  logic                i_tx_done,
  output logic                o_prog_we,
  output logic [NB_PADDR-1:0] o_prog_addr,
  output logic [LEN-1:0]      o_prog_data,
  output logic                o_cpu_en,
  output logic                o_cpu_rst,
  input  logic                i_cpu_halt,
  input  logic [LEN-1:0]      i_pc
);

  localparam int NB_BYTES = LEN / 8;
  localparam int NB_BIDX  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam logic [NB_BIDX-1:0]  LAST_BYTE = NB_BIDX'(NB_BYTES - 1);
  localparam logic [NB_BIDX-1:0]  BIDX_ONE  = NB_BIDX'(1);
  localparam logic [NB_PADDR-1:0] LAST_ADDR = NB_PADDR'(RAM_DEPTH_PROGRAM - 1);
  localparam logic [NB_PADDR-1:0] ADDR_ONE  = NB_PADDR'(1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_CNT  = 3'd1,
    ST_LOAD_BYTE = 3'd2,
    ST_WRITE     = 3'd3,
    ST_RUN       = 3'd4,
    ST_STEP      = 3'd5,
    ST_SEND_PC   = 3'd6,
    ST_WAIT_TX   = 3'd7
  } state_t;

  // Byte idx of the PC, index 0 being the most significant byte.
  function automatic logic [7:0] pc_byte(input logic [LEN-1:0] pc, input logic [NB_BIDX-1:0] idx);
    logic [LEN-1:0] sh;
    sh = pc >> (8 * (NB_BYTES - 1 - int'(idx)));
    return sh[7:0];
  endfunction

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          word_cnt_q, word_cnt_d;
  logic [NB_PADDR-1:0] addr_q, addr_d;
  logic [NB_BIDX-1:0]  byte_idx_q, byte_idx_d;
  logic [LEN-1:0]      word_q, word_d;
  logic [LEN-1:0]      pc_q, pc_d;
  logic                step_q, step_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                prog_we_q, prog_we_d;
  logic [NB_PADDR-1:0] prog_addr_q, prog_addr_d;
  logic [LEN-1:0]      prog_data_q, prog_data_d;
  logic                cpu_en_q, cpu_en_d;
  logic                cpu_rst_q, cpu_rst_d;

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_cnt_d  = word_cnt_q;
    addr_d      = addr_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    pc_d        = pc_q;
    step_d      = step_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    prog_we_d   = 1'b0;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    cpu_en_d    = 1'b0;
    cpu_rst_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            8'h4C:   state_d = ST_LOAD_CNT;
            8'h52:   state_d = ST_RUN;
            8'h53: begin
              state_d  = ST_STEP;
              step_d   = 1'b0;
              cpu_en_d = 1'b1;
            end
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD_CNT: begin
        if (i_rx_valid) begin
          cnt_d      = i_rx_data;
          word_cnt_d = 8'd0;
          addr_d     = {NB_PADDR{1'b0}};
          byte_idx_d = {NB_BIDX{1'b0}};
          state_d    = (i_rx_data == 8'h00) ? ST_IDLE : ST_LOAD_BYTE;
        end else begin
          state_d = ST_LOAD_CNT;
        end
      end
      ST_LOAD_BYTE: begin
        if (i_rx_valid) begin
          word_d = {word_q[LEN-9:0], i_rx_data};
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_d  = {NB_BIDX{1'b0}};
            prog_addr_d = addr_q;
            prog_data_d = word_d;
            state_d     = ST_WRITE;
          end else begin
            byte_idx_d = byte_idx_q + BIDX_ONE;
          end
        end else begin
          state_d = ST_LOAD_BYTE;
        end
      end
      ST_WRITE: begin
        word_cnt_d = word_cnt_q + 8'd1;
        addr_d     = (addr_q == LAST_ADDR) ? {NB_PADDR{1'b0}} : addr_q + ADDR_ONE;
        state_d    = (word_cnt_d == cnt_q) ? ST_IDLE : ST_LOAD_BYTE;
      end
      ST_RUN: begin
        if (i_cpu_halt) begin
          pc_d       = i_pc;
          byte_idx_d = {NB_BIDX{1'b0}};
          state_d    = ST_SEND_PC;
        end else begin
          cpu_en_d = 1'b1;
        end
      end
      ST_STEP: begin
        // Second cycle lets the stepped PC settle before it is captured.
        if (step_q) begin
          step_d     = 1'b0;
          pc_d       = i_pc;
          byte_idx_d = {NB_BIDX{1'b0}};
          state_d    = ST_SEND_PC;
        end else begin
          step_d = 1'b1;
        end
      end
      ST_SEND_PC: state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_d = {NB_BIDX{1'b0}};
            state_d    = ST_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + BIDX_ONE;
            state_d    = ST_SEND_PC;
          end
        end else begin
          state_d = ST_WAIT_TX;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_SEND_PC) begin
      tx_start_d = 1'b1;
      tx_data_d  = pc_byte(pc_d, byte_idx_d);
    end else begin
      tx_start_d = 1'b0;
    end
    prog_we_d = (state_d == ST_WRITE);
    cpu_rst_d = (state_d == ST_LOAD_CNT) || (state_d == ST_LOAD_BYTE) || (state_d == ST_WRITE);
  end

  // State, counters and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      word_cnt_q  <= 8'd0;
      addr_q      <= {NB_PADDR{1'b0}};
      byte_idx_q  <= {NB_BIDX{1'b0}};
      word_q      <= {LEN{1'b0}};
      pc_q        <= {LEN{1'b0}};
      step_q      <= 1'b0;
      tx_data_q   <= 8'd0;
      tx_start_q  <= 1'b0;
      prog_we_q   <= 1'b0;
      prog_addr_q <= {NB_PADDR{1'b0}};
      prog_data_q <= {LEN{1'b0}};
      cpu_en_q    <= 1'b0;
      cpu_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_cnt_q  <= word_cnt_d;
      addr_q      <= addr_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      pc_q        <= pc_d;
      step_q      <= step_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      prog_we_q   <= prog_we_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      cpu_en_q    <= cpu_en_d;
      cpu_rst_q   <= cpu_rst_d;
    end
  end

  assign o_tx_data   = tx_data_q;
  assign o_tx_start  = tx_start_q;
  assign o_prog_we   = prog_we_q;
  assign o_prog_addr = prog_addr_q;
  assign o_prog_data = prog_data_q;
  assign o_cpu_en    = cpu_en_q;
  assign o_cpu_rst   = cpu_rst_q;

endmodule

// File: tb/tb_mips_debug_unit.sv
// Directed self-checking bench for mips_debug_unit: load, wrap, run, step,
// PC transmission handshake and reset aborts.
module tb_mips_debug_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [31:0] prog_data;
  logic        cpu_en;
  logic        cpu_rst;
  logic        cpu_halt;
  logic [31:0] pc;

  int errors = 0;
  int checks = 0;

  int wr_n = 0, tx_n = 0, en_n = 0, both_n = 0, rst_bad = 0;
  logic [4:0]  wr_addr [0:127];
  logic [31:0] wr_data [0:127];

  always #5 clk = ~clk;

  mips_debug_unit #(.LEN(32), .RAM_DEPTH_PROGRAM(32), .NB_PADDR(5)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
    .o_prog_we(prog_we), .o_prog_addr(prog_addr), .o_prog_data(prog_data),
    .o_cpu_en(cpu_en), .o_cpu_rst(cpu_rst), .i_cpu_halt(cpu_halt), .i_pc(pc)
  );

  // Event log sampled mid-cycle.
  always @(negedge clk) begin
    if (prog_we) begin
      wr_addr[wr_n[6:0]] <= prog_addr;
      wr_data[wr_n[6:0]] <= prog_data;
      wr_n <= wr_n + 1;
      if (!cpu_rst) rst_bad <= rst_bad + 1;
    end
    if (tx_start) tx_n <= tx_n + 1;
    if (cpu_en) en_n <= en_n + 1;
    if (prog_we && tx_start) both_n <= both_n + 1;
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1; rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1; rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_done();
    @(posedge clk); #1; tx_done = 1'b1;
    @(posedge clk); #1; tx_done = 1'b0;
  endtask

  // Acts as the UART transmitter for the four PC bytes following tx_n == base.
  task automatic serve_tx(input int base, output logic [31:0] word, output int early, output int tmo);
    word = 32'h0; early = 0; tmo = 0;
    for (int k = 0; k < 4; k++) begin
      int w;
      w = 0;
      while (tx_n <= base + k && w < 100) begin @(negedge clk); w++; end
      if (tx_n <= base + k) begin
        tmo++;
      end else begin
        word = {word[23:0], tx_data};
        repeat (4) @(negedge clk);
        if (tx_n != base + k + 1 || tx_data !== word[7:0]) early++;
        pulse_done();
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({tx_data, tx_start, prog_we, prog_addr, prog_data, cpu_en} !== 48'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {tx_data, tx_start, prog_we, prog_addr, prog_data, cpu_en});
    end
    checks++;
    if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst); end
    rst = 1'b0;
    #1;
    checks++;
    if (cpu_rst !== 1'b1) begin errors++; $display("FAIL cpu_rst_before_edge: got %b want 1", cpu_rst); end
    @(negedge clk);
    checks++;
    if (cpu_rst !== 1'b0) begin errors++; $display("FAIL cpu_rst_after_edge: got %b want 0", cpu_rst); end
  endtask

  task automatic test_load();
    logic [7:0] seq [0:8] = '{8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'hFC, 8'h00, 8'h00, 8'h00};
    int base, low;
    logic [6:0] bi;
    base = wr_n; low = 0; bi = base[6:0];
    send_byte(8'h4C);
    @(negedge clk); if (!cpu_rst) low++;
    for (int i = 0; i < 9; i++) begin
      send_byte(seq[i]);
      @(negedge clk); if (!cpu_rst) low++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (wr_n - base != 2) begin errors++; $display("FAIL load_count: got %0d want 2", wr_n - base); end
    checks++;
    if (wr_addr[bi] !== 5'd0 || wr_data[bi] !== 32'h2001_0005) begin
      errors++; $display("FAIL load_word0: got %0d/%h want 0/20010005", wr_addr[bi], wr_data[bi]);
    end
    checks++;
    if (wr_addr[bi + 7'd1] !== 5'd1 || wr_data[bi + 7'd1] !== 32'hFC00_0000) begin
      errors++; $display("FAIL load_word1: got %0d/%h want 1/fc000000", wr_addr[bi + 7'd1], wr_data[bi + 7'd1]);
    end
    checks++;
    if (low != 0) begin errors++; $display("FAIL load_cpu_rst_high: got %0d low samples want 0", low); end
    checks++;
    if (cpu_rst !== 1'b0) begin errors++; $display("FAIL load_cpu_rst_after: got %b want 0", cpu_rst); end
  endtask

  task automatic test_zero_len();
    int base;
    base = wr_n;
    send_byte(8'h4C);
    @(negedge clk);
    checks++;
    if (cpu_rst !== 1'b1) begin errors++; $display("FAIL zero_cpu_rst: got %b want 1", cpu_rst); end
    send_byte(8'h00);
    repeat (3) @(negedge clk);
    checks++;
    if (wr_n - base != 0 || cpu_rst !== 1'b0) begin
      errors++; $display("FAIL zero_len: got writes=%0d cpu_rst=%b want 0/0", wr_n - base, cpu_rst);
    end
  endtask

  task automatic test_wrap();
    int base, bad;
    logic [6:0] bi;
    base = wr_n; bad = 0; bi = base[6:0];
    send_byte(8'h4C);
    send_byte(8'h21);
    for (int i = 0; i < 33; i++) send_word(32'h1000_0000 + 32'(i));
    repeat (3) @(negedge clk);
    checks++;
    if (wr_n - base != 33) begin errors++; $display("FAIL wrap_count: got %0d want 33", wr_n - base); end
    for (int i = 0; i < 33; i++) begin
      logic [4:0] ea;
      ea = 5'(i % 32);
      if (wr_addr[bi + 7'(i)] !== ea) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL wrap_addr_seq: got %0d wrong addresses want 0", bad); end
    checks++;
    if (wr_addr[bi + 7'd32] !== 5'd0 || wr_data[bi + 7'd32] !== 32'h1000_0020) begin
      errors++; $display("FAIL wrap_last: got %0d/%h want 0/10000020", wr_addr[bi + 7'd32], wr_data[bi + 7'd32]);
    end
  endtask

  task automatic test_run();
    int ebase, tbase, n, w, early, tmo;
    logic [31:0] word;
    pc = 32'h1111_0000; cpu_halt = 1'b0;
    ebase = en_n; tbase = tx_n; n = 0; w = 0;
    send_byte(8'h52);
    while (n < 10 && w < 100) begin
      @(negedge clk); w++;
      if (cpu_en) n++;
    end
    cpu_halt = 1'b1; pc = 32'h0000_002C;
    checks++;
    if (n != 10) begin errors++; $display("FAIL run_en_timeout: got %0d enabled cycles want 10", n); end
    serve_tx(tbase, word, early, tmo);
    checks++;
    if (word !== 32'h0000_002C) begin errors++; $display("FAIL run_pc: got %h want 0000002c", word); end
    checks++;
    if (early != 0 || tmo != 0) begin errors++; $display("FAIL run_tx_handshake: got early=%0d tmo=%0d want 0/0", early, tmo); end
    checks++;
    if (en_n - ebase != 10) begin errors++; $display("FAIL run_en_cycles: got %0d want 10", en_n - ebase); end
    cpu_halt = 1'b0;
  endtask

  task automatic test_run_halted();
    int ebase, tbase, early, tmo;
    logic [31:0] word;
    cpu_halt = 1'b1; pc = 32'h1234_5678;
    ebase = en_n; tbase = tx_n;
    send_byte(8'h52);
    serve_tx(tbase, word, early, tmo);
    checks++;
    if (word !== 32'h1234_5678 || tmo != 0) begin errors++; $display("FAIL halted_run_pc: got %h tmo=%0d want 12345678", word, tmo); end
    checks++;
    if (en_n - ebase != 0) begin errors++; $display("FAIL halted_run_en: got %0d want 0", en_n - ebase); end
    cpu_halt = 1'b0;
  endtask

  task automatic test_step();
    int ebase, tbase, w, early, tmo;
    logic [31:0] word;
    pc = 32'h0; ebase = en_n; tbase = tx_n; w = 0;
    send_byte(8'h53);
    @(negedge clk);
    while (!cpu_en && w < 20) begin @(negedge clk); w++; end
    pc = 32'h0000_0004;
    send_byte(8'h4C);
    @(negedge clk);
    checks++;
    if (cpu_rst !== 1'b0) begin errors++; $display("FAIL step_rx_ignored: got cpu_rst=%b want 0", cpu_rst); end
    serve_tx(tbase, word, early, tmo);
    checks++;
    if (word !== 32'h0000_0004 || early != 0 || tmo != 0) begin
      errors++; $display("FAIL step_pc: got %h early=%0d tmo=%0d want 00000004", word, early, tmo);
    end
    checks++;
    if (en_n - ebase != 1) begin errors++; $display("FAIL step_en_cycles: got %0d want 1", en_n - ebase); end
  endtask

  task automatic test_reset_mid_load();
    int base;
    logic [6:0] bi;
    base = wr_n; bi = base[6:0];
    send_byte(8'h4C); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (prog_we !== 1'b0 || tx_start !== 1'b0 || cpu_rst !== 1'b1 || prog_data !== 32'h0) begin
      errors++; $display("FAIL midload_reset_outputs: got we=%b start=%b cpu_rst=%b data=%h", prog_we, tx_start, cpu_rst, prog_data);
    end
    rst = 1'b0;
    send_byte(8'h4C); send_byte(8'h01);
    send_word(32'h1122_3344);
    repeat (3) @(negedge clk);
    checks++;
    if (wr_n - base != 1) begin errors++; $display("FAIL midload_count: got %0d want 1", wr_n - base); end
    checks++;
    if (wr_addr[bi] !== 5'd0 || wr_data[bi] !== 32'h1122_3344) begin
      errors++; $display("FAIL midload_word: got %0d/%h want 0/11223344", wr_addr[bi], wr_data[bi]);
    end
  endtask

  task automatic test_reset_mid_send();
    int tbase, w;
    cpu_halt = 1'b1; pc = 32'hCAFE_0001; tbase = tx_n; w = 0;
    send_byte(8'h52);
    while (tx_n <= tbase && w < 100) begin @(negedge clk); w++; end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (3) pulse_done();
    repeat (5) @(negedge clk);
    checks++;
    if (tx_n - tbase != 1) begin errors++; $display("FAIL midsend_tx_pulses: got %0d want 1", tx_n - tbase); end
    cpu_halt = 1'b0;
  endtask

  task automatic test_back_to_back();
    int ebase, tbase, wbase, early, tmo;
    logic [31:0] word;
    logic [6:0] bi;
    ebase = en_n; tbase = tx_n; wbase = wr_n; bi = wbase[6:0];
    send_byte(8'h41);
    pulse_done();
    repeat (2) @(negedge clk);
    checks++;
    if (cpu_rst !== 1'b0 || en_n != ebase || tx_n != tbase) begin
      errors++; $display("FAIL ignored_inputs: got cpu_rst=%b en=%0d tx=%0d want 0/0/0", cpu_rst, en_n - ebase, tx_n - tbase);
    end
    pc = 32'h0000_0040;
    send_byte(8'h4C); send_byte(8'h01);
    send_word(32'hDEAD_BEEF);
    send_byte(8'h53);
    serve_tx(tbase, word, early, tmo);
    checks++;
    if (wr_n - wbase != 1 || wr_addr[bi] !== 5'd0 || wr_data[bi] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL b2b_write: got n=%0d %0d/%h want 1 0/deadbeef", wr_n - wbase, wr_addr[bi], wr_data[bi]);
    end
    checks++;
    if (word !== 32'h0000_0040 || tmo != 0) begin errors++; $display("FAIL b2b_step_pc: got %h tmo=%0d want 00000040", word, tmo); end
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_done = 1'b0; cpu_halt = 1'b0; pc = 32'h0;
    test_reset();
    test_load();
    test_zero_len();
    test_wrap();
    test_run();
    test_run_halted();
    test_step();
    test_reset_mid_load();
    test_reset_mid_send();
    test_back_to_back();
    checks++;
    if (both_n != 0) begin errors++; $display("FAIL we_and_tx_start: got %0d overlaps want 0", both_n); end
    checks++;
    if (rst_bad != 0) begin errors++; $display("FAIL write_cpu_rst: got %0d writes with cpu_rst low want 0", rst_bad); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
